// File: rtl/pmips_interlock_control_if.sv
// Signal bundle between the IF/ID stage and the PMIPS issue controller.
// The pipeline side drives the instruction word; the controller answers with stall and ID/EX controls.
interface pmips_interlock_control_if;
  logic [15:0] IFID;
  logic        PCStall;
  logic        RegWrite;
  logic        RegDst;
  logic        ALUSrc;
  logic        Branch;
  logic        MemWrite;
  logic        MemRead;
  logic        MemtoReg;
  logic [1:0]  ALUOp;
  logic        Issued;
  logic        Hazard;

  modport master (
    output IFID,
    input  PCStall, RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemRead, MemtoReg,
    input  ALUOp, Issued, Hazard
  );

  modport slave (
    input  IFID,
    output PCStall, RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemRead, MemtoReg,
    output ALUOp, Issued, Hazard
  );
endinterface

// File: rtl/pmips_interlock_control.sv
// PMIPS issue controller: per-register write scoreboard for RAW interlocks plus a
// configurable branch-penalty wait. Control outputs are decoded combinationally from IF/ID.
module pmips_interlock_control #(
  parameter int unsigned WB_LAT     = 3,
  parameter int unsigned BR_PENALTY = 3,
  parameter int unsigned NREG       = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  pmips_interlock_control_if.slave  bus
);

  localparam int unsigned CW = $clog2(WB_LAT + 1);

  localparam logic [2:0] OP_RTYPE = 3'd0;
  localparam logic [2:0] OP_BEQ   = 3'd2;
  localparam logic [2:0] OP_ADDI  = 3'd3;
  localparam logic [2:0] OP_LW    = 3'd5;
  localparam logic [2:0] OP_SW    = 3'd6;

  typedef enum logic [1:0] {ST_RESET, ST_ISSUE, ST_BRWAIT} state_e;

  typedef struct packed {
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src;
    logic       branch;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic [1:0] alu_op;
  } ctrl_t;

  state_e        state_q, state_d;
  logic [3:0]    br_cnt_q, br_cnt_d;
  logic [CW-1:0] sb_q [NREG];
  logic [CW-1:0] sb_d [NREG];

  logic [2:0] opcode, rs, rt, rd, dst;
  logic       reads_rs, reads_rt, writes_dst;
  logic       rs_pend, rt_pend, hazard, issue;
  logic [NREG-1:0] pend;
  ctrl_t      dec;
  logic       unused_funct;

  assign opcode       = bus.IFID[15:13];
  assign rs           = bus.IFID[12:10];
  assign rt           = bus.IFID[9:7];
  assign rd           = bus.IFID[6:4];
  // funct is resolved by the ALU control stage once ALUOp selects R-type.
  assign unused_funct = ^bus.IFID[3:0];

  // NOTE: every signal written in a combinational block gets a default first, so no path can infer a latch.
  always_comb begin
    dec        = '0;
    reads_rs   = 1'b0;
    reads_rt   = 1'b0;
    writes_dst = 1'b0;
    dst        = 3'd0;
    unique case (opcode)
      OP_RTYPE: begin
        dec.reg_dst = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 2'd2;
        reads_rs = 1'b1; reads_rt = 1'b1; writes_dst = 1'b1; dst = rd;
      end
      OP_BEQ: begin
        dec.branch = 1'b1; dec.alu_op = 2'd1;
        reads_rs = 1'b1; reads_rt = 1'b1;
      end
      OP_ADDI: begin
        dec.alu_src = 1'b1; dec.reg_write = 1'b1;
        reads_rs = 1'b1; writes_dst = 1'b1; dst = rt;
      end
      OP_LW: begin
        dec.alu_src = 1'b1; dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1; dec.reg_write = 1'b1;
        reads_rs = 1'b1; writes_dst = 1'b1; dst = rt;
      end
      OP_SW: begin
        dec.alu_src = 1'b1; dec.mem_write = 1'b1;
        reads_rs = 1'b1; reads_rt = 1'b1;
      end
      default: ;
    endcase
  end

  // Register 0 is hard-wired zero and therefore never pending.
  always_comb begin
    for (int i = 0; i < int'(NREG); i++) begin
      pend[i] = (i != 0) && (sb_q[i] != '0);
    end
  end

  assign rs_pend = (int'(rs) < int'(NREG)) ? pend[rs] : 1'b0;
  assign rt_pend = (int'(rt) < int'(NREG)) ? pend[rt] : 1'b0;

  always_comb begin
    bus.PCStall  = 1'b1;
    bus.RegWrite = 1'b0;
    bus.RegDst   = 1'b0;
    bus.ALUSrc   = 1'b0;
    bus.Branch   = 1'b0;
    bus.MemWrite = 1'b0;
    bus.MemRead  = 1'b0;
    bus.MemtoReg = 1'b0;
    bus.ALUOp    = 2'd0;
    bus.Issued   = 1'b0;
    bus.Hazard   = 1'b0;
    hazard       = 1'b0;
    issue        = 1'b0;
    if (state_q == ST_ISSUE) begin
      hazard = (reads_rs && rs_pend) || (reads_rt && rt_pend);
      if (hazard) begin
        bus.Hazard = 1'b1;
      end else begin
        issue        = 1'b1;
        bus.PCStall  = 1'b0;
        bus.Issued   = 1'b1;
        bus.RegWrite = dec.reg_write;
        bus.RegDst   = dec.reg_dst;
        bus.ALUSrc   = dec.alu_src;
        bus.Branch   = dec.branch;
        bus.MemWrite = dec.mem_write;
        bus.MemRead  = dec.mem_read;
        bus.MemtoReg = dec.mem_to_reg;
        bus.ALUOp    = dec.alu_op;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    br_cnt_d = br_cnt_q;
    unique case (state_q)
      ST_RESET: state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (issue && (opcode == OP_BEQ) && (BR_PENALTY > 0)) begin
          state_d  = ST_BRWAIT;
          br_cnt_d = 4'(BR_PENALTY);
        end
      end
      ST_BRWAIT: begin
        br_cnt_d = br_cnt_q - 4'd1;
        if (br_cnt_q <= 4'd1) state_d = ST_ISSUE;
      end
      default: state_d = ST_RESET;
    endcase
  end

  // A load on issue overrides the per-cycle decrement, which also gives WAW reloads.
  always_comb begin
    for (int i = 0; i < int'(NREG); i++) begin
      sb_d[i] = sb_q[i];
      if ((state_q != ST_RESET) && (sb_q[i] != '0)) sb_d[i] = sb_q[i] - CW'(1);
    end
    if (issue && writes_dst && (dst != 3'd0) && (int'(dst) < int'(NREG))) begin
      sb_d[dst] = CW'(WB_LAT);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  // NOTE: the scoreboard array is reset explicitly; stale pending bits after reset would stall issue.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_RESET;
      br_cnt_q <= 4'd0;
      for (int i = 0; i < int'(NREG); i++) sb_q[i] <= '0;
    end else begin
      state_q  <= state_d;
      br_cnt_q <= br_cnt_d;
      for (int i = 0; i < int'(NREG); i++) sb_q[i] <= sb_d[i];
    end
  end

endmodule

// File: tb/tb_pmips_interlock_control.sv
// Directed bench for pmips_interlock_control: expected output vectors are queued as each
// instruction is driven and compared against both controller instances at the falling edge.
module tb_pmips_interlock_control;

  logic clock;
  logic reset;

  pmips_interlock_control_if bus_a ();
  pmips_interlock_control_if bus_b ();

  pmips_interlock_control #(.WB_LAT(3), .BR_PENALTY(2), .NREG(8)) u_dut_a (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  pmips_interlock_control #(.WB_LAT(3), .BR_PENALTY(0), .NREG(8)) u_dut_b (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Output vector: {PCStall, RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemRead, MemtoReg, ALUOp[1:0], Issued, Hazard}
  localparam logic [11:0] E_RST   = 12'h800; // stall only
  localparam logic [11:0] E_BUB   = 12'h800; // bubble without hazard
  localparam logic [11:0] E_HAZ   = 12'h801; // bubble with Hazard
  localparam logic [11:0] E_ADDI  = 12'h502; // RegWrite, ALUSrc, Issued
  localparam logic [11:0] E_RTYPE = 12'h60A; // RegWrite, RegDst, ALUOp=2, Issued
  localparam logic [11:0] E_BEQ   = 12'h086; // Branch, ALUOp=1, Issued
  localparam logic [11:0] E_LW    = 12'h532; // RegWrite, ALUSrc, MemRead, MemtoReg, Issued
  localparam logic [11:0] E_SW    = 12'h142; // ALUSrc, MemWrite, Issued
  localparam logic [11:0] E_NOP   = 12'h002; // Issued only

  logic [11:0] obs_a, obs_b;
  assign obs_a = {bus_a.PCStall, bus_a.RegWrite, bus_a.RegDst, bus_a.ALUSrc, bus_a.Branch,
                  bus_a.MemWrite, bus_a.MemRead, bus_a.MemtoReg, bus_a.ALUOp, bus_a.Issued, bus_a.Hazard};
  assign obs_b = {bus_b.PCStall, bus_b.RegWrite, bus_b.RegDst, bus_b.ALUSrc, bus_b.Branch,
                  bus_b.MemWrite, bus_b.MemRead, bus_b.MemtoReg, bus_b.ALUOp, bus_b.Issued, bus_b.Hazard};

  typedef struct {
    string       tag;
    bit          sel_b;
    logic [11:0] exp;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic logic [15:0] enc(input logic [2:0] op, input logic [2:0] rs,
                                      input logic [2:0] rt, input logic [6:0] low);
    return {op, rs, rt, low};
  endfunction

  function automatic logic [15:0] rtype(input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
    return {3'd0, rs, rt, rd, 4'd0};
  endfunction

  localparam logic [15:0] NOP = 16'h2000; // opcode 1

  task automatic expect_out(input string tag, input bit sel_b, input logic [11:0] e);
    exp_t x;
    x.tag   = tag;
    x.sel_b = sel_b;
    x.exp   = e;
    exp_q.push_back(x);
  endtask

  task automatic compare_all();
    exp_t        x;
    logic [11:0] o;
    while (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      o = x.sel_b ? obs_b : obs_a;
      checks++;
      assert (o === x.exp)
        else begin
          failures++;
          $error("FAIL %s observed=%h expected=%h", x.tag, o, x.exp);
        end
    end
  endtask

  // One clock on controller A; controller B idles on nops.
  task automatic cyc(input logic [15:0] ins, input logic [11:0] e, input string tag);
    bus_a.IFID = ins;
    bus_b.IFID = NOP;
    expect_out(tag, 1'b0, e);
    @(negedge clock);
    compare_all();
    @(posedge clock);
    #1;
  endtask

  // One clock on controller B; controller A sees a nop and must issue it.
  task automatic cycb(input logic [15:0] ins, input logic [11:0] e, input string tag);
    bus_a.IFID = NOP;
    bus_b.IFID = ins;
    expect_out({tag, "_a_nop"}, 1'b0, E_NOP);
    expect_out(tag, 1'b1, e);
    @(negedge clock);
    compare_all();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b0;
    bus_a.IFID = NOP;
    bus_b.IFID = NOP;
    @(posedge clock);
    #1;

    // Reset held: outputs stay at reset values whatever IF/ID holds.
    for (int i = 0; i < 3; i++) cyc(enc(3'd3, 3'd0, 3'd1, 7'd5), E_RST, "rst_low");
    reset = 1'b1;
    cyc(enc(3'd3, 3'd0, 3'd1, 7'd5), E_RST, "rst_release_stall");
    cyc(enc(3'd3, 3'd0, 3'd1, 7'd5), E_ADDI, "first_issue");

    // RAW on r1: exactly three hazard bubbles, then the add issues.
    for (int i = 0; i < 3; i++) cyc(rtype(3'd2, 3'd1, 3'd1), E_HAZ, "raw_bubble");
    cyc(rtype(3'd2, 3'd1, 3'd1), E_RTYPE, "raw_issue");

    // Independent stream issues back to back.
    cyc(enc(3'd3, 3'd0, 3'd3, 7'd1), E_ADDI, "indep_1");
    cyc(enc(3'd3, 3'd0, 3'd4, 7'd2), E_ADDI, "indep_2");
    cyc(enc(3'd3, 3'd0, 3'd5, 7'd3), E_ADDI, "indep_3");

    // Branch penalty 2 on controller A.
    cyc(enc(3'd2, 3'd0, 3'd0, 7'd0), E_BEQ, "beq_issue");
    cyc(enc(3'd3, 3'd0, 3'd6, 7'd1), E_BUB, "br_bubble1");
    cyc(enc(3'd3, 3'd0, 3'd6, 7'd1), E_BUB, "br_bubble2");
    cyc(enc(3'd3, 3'd0, 3'd6, 7'd1), E_ADDI, "br_next_issue");

    // Branch penalty 0 on controller B: next instruction issues immediately.
    cycb(enc(3'd2, 3'd0, 3'd0, 7'd0), E_BEQ, "beq0_issue");
    cycb(enc(3'd3, 3'd0, 3'd6, 7'd1), E_ADDI, "beq0_next");

    // WAW: the second lw reloads r1, so the reader waits three cycles after it.
    cyc(enc(3'd5, 3'd0, 3'd1, 7'd0), E_LW, "waw_lw1");
    cyc(enc(3'd5, 3'd0, 3'd1, 7'd0), E_LW, "waw_lw2");
    for (int i = 0; i < 3; i++) cyc(rtype(3'd2, 3'd1, 3'd0), E_HAZ, "waw_bubble");
    cyc(rtype(3'd2, 3'd1, 3'd0), E_RTYPE, "waw_issue");

    // Writes to r0 never create a pending entry.
    cyc(enc(3'd3, 3'd0, 3'd0, 7'd9), E_ADDI, "r0_write");
    cyc(rtype(3'd2, 3'd0, 3'd0), E_RTYPE, "r0_read");
    cyc(enc(3'd6, 3'd0, 3'd0, 7'd4), E_SW, "sw_issue");

    // Reset during the second RAW bubble clears the scoreboard.
    cyc(enc(3'd3, 3'd0, 3'd1, 7'd7), E_ADDI, "pre_rst_producer");
    cyc(rtype(3'd3, 3'd1, 3'd1), E_HAZ, "rst_bubble1");
    bus_a.IFID = rtype(3'd3, 3'd1, 3'd1);
    expect_out("rst_bubble2", 1'b0, E_HAZ);
    #2;
    compare_all();
    reset = 1'b0;
    #1;
    expect_out("async_rst", 1'b0, E_RST);
    compare_all();
    @(posedge clock);
    #1;
    cyc(rtype(3'd3, 3'd1, 3'd1), E_RST, "rst_mid_low");
    reset = 1'b1;
    cyc(rtype(3'd3, 3'd1, 3'd1), E_RST, "rst_mid_release");
    cyc(rtype(3'd3, 3'd1, 3'd1), E_RTYPE, "no_stale_hazard");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pmips_interlock_control.md
# pmips_interlock_control

Parametrised issue controller for the PMIPS 16-bit pipeline. It replaces the fixed "issue, then always stall three cycles" sequencer with a per-register scoreboard. An instruction in IF/ID issues as soon as its source registers have no pending write. Branches stall for a configurable penalty. The block sits between the IF/ID pipeline register and the ID/EX control fields, and it drives the PC stall line.

## Interface
Parameters:
- `WB_LAT`, default 3: cycles from issue until the result is readable from the register file; range 1–15.
- `BR_PENALTY`, default 3: bubble cycles inserted after a `beq` issues; range 0–15.
- `NREG`, default 8: architectural register count; register 0 is hard-wired zero.

Ports:
- `clock`, in, 1: single clock; all state updates on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `IFID`, in, 16: instruction in IF/ID. Fields: opcode [15:13], rs [12:10], rt [9:7], rd [6:4], funct [3:0].
- `PCStall`, out, 1: 1 = hold the PC and IF/ID.
- `RegWrite`, `RegDst`, `ALUSrc`, `Branch`, `MemWrite`, `MemRead`, `MemtoReg`, out, 1 each: datapath controls for the issuing instruction.
- `ALUOp`, out, 2: 0 = add, 1 = sub, 2 = R-type (decoded from funct).
- `Issued`, out, 1: 1 = IF/ID instruction enters ID/EX this cycle.
- `Hazard`, out, 1: 1 = stall is caused by a scoreboard conflict.

## Operation
- **States:** RESET, ISSUE, BRWAIT. All outputs are combinational from state, scoreboard and `IFID`.
- **RESET:**
  - Entered asynchronously while `reset` = 0.
  - Outputs: `PCStall` = 1; all other outputs 0; scoreboard cleared; branch counter cleared.
  - Stays in RESET for exactly one clock after `reset` rises, then moves to ISSUE.
- **Bubble:** `PCStall` = 1; `RegWrite`, `MemWrite`, `MemRead`, `Branch`, `Issued` = 0; remaining controls 0.
- **Decode in ISSUE:**
  - Opcode 0 (R-type): `RegDst` = 1, `RegWrite` = 1, `ALUOp` = 2; reads rs, rt; writes rd.
  - Opcode 2 (beq): `Branch` = 1, `ALUOp` = 1; reads rs, rt.
  - Opcode 3 (addi): `ALUSrc` = 1, `RegWrite` = 1; reads rs; writes rt.
  - Opcode 5 (lw): `ALUSrc` = 1, `MemRead` = 1, `MemtoReg` = 1, `RegWrite` = 1; reads rs; writes rt.
  - Opcode 6 (sw): `ALUSrc` = 1, `MemWrite` = 1; reads rs, rt.
  - Other opcodes: treated as nop; `Issued` = 1, `PCStall` = 0, all controls 0.
- **Scoreboard:**
  - One down-counter per register, each `$clog2(WB_LAT+1)` bits.
  - A register is pending when its counter ≠ 0.
  - Register 0 is never pending and is never set.
- **Hazard:**
  - Asserted in ISSUE when any source register read by the decoded opcode is pending.
  - On hazard the block outputs a bubble and stays in ISSUE.
- **Issue** (ISSUE and no hazard):
  - Decoded controls drive the outputs; `PCStall` = 0; `Issued` = 1.
  - If the instruction writes a nonzero destination, that register's counter loads `WB_LAT` at the clock edge.
  - If opcode = 2 and `BR_PENALTY` > 0, the next state is BRWAIT with the branch counter = `BR_PENALTY`.
- **BRWAIT:**
  - Outputs a bubble; `Hazard` = 0.
  - The branch counter decrements each clock; the state returns to ISSUE in the cycle after the counter reaches 1.
- **Every clock:** all nonzero counters decrement by 1 (saturate at 0), in every state except RESET.
- **Simultaneous set and decrement** on the same register: the set wins (counter = `WB_LAT`).
- **WAW:** reissuing a write to a pending register reloads its counter to `WB_LAT`.
- **Reset mid-operation:** immediately forces RESET outputs; any pending branch wait and all scoreboard entries are discarded.

## Timing
- **Issue-to-dependent:** a producer issued in cycle t sets its counter to `WB_LAT` for cycle t+1. A reader of that register stalls in cycles t+1…t+`WB_LAT` and issues in cycle t+`WB_LAT`+1, i.e. exactly `WB_LAT` bubbles.
- **Independent instructions:** issue back-to-back, one per clock.
- **beq:** issued in cycle t; bubbles in cycles t+1…t+`BR_PENALTY`; the next issue is possible in cycle t+`BR_PENALTY`+1.
- **Latency:** zero-cycle combinational decode from `IFID` to the control outputs; the scoreboard and state have one-cycle update latency.
- **Hazard in BRWAIT:** not evaluated; BRWAIT bubbles are not counted as hazards.

## Test plan
- **Reset release:** hold `reset` = 0 for 3 clocks → `PCStall` = 1, all other outputs 0. Release → one more stall cycle, then with `IFID` = addi r1,r0,5: `Issued` = 1, `RegWrite` = 1, `ALUSrc` = 1.
- **RAW with `WB_LAT` = 3:** addi r1 then add r2,r1,r1 → exactly 3 bubble cycles with `Hazard` = 1, then the add issues with `RegDst` = 1, `ALUOp` = 2.
- **Independent stream:** addi r1, addi r2, addi r3 (sources r0) → `Issued` = 1 on 3 consecutive clocks, `PCStall` = 0 throughout.
- **Branch penalty:** beq r0,r0 with `BR_PENALTY` = 2 → `Branch` = 1 for one cycle, then 2 bubbles with `Hazard` = 0, then the next instruction issues. With `BR_PENALTY` = 0, the next instruction issues the following cycle.
- **WAW and r0:**
  - lw r1; lw r1 one cycle later; add r2,r1,r0 → the add issues `WB_LAT` cycles after the second lw.
  - addi r0,…; add r2,r0,r0 immediately after → no stall.
- **Reset mid-stall:** assert `reset` during the second RAW bubble → outputs go to reset values asynchronously. After release and the one RESET cycle, the formerly dependent add issues with no hazard.
